// File: rtl/text_buffer_ctrl.sv
// Text-mode buffer controller: turns keyboard ASCII codes into text RAM writes and cursor moves over a 4x16 grid.
// Optional scrolling on overflow is compiled in with the TEXT_BUFFER_SCROLL_EN macro; otherwise the cursor wraps to 0.
module text_buffer_ctrl #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  output logic       key_ready,
  input  logic       clear_req,
  output logic [5:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       ram_we,
  input  logic [7:0] ram_rdata,
  output logic [5:0] cursor,
  output logic       busy
);

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] LAST_ADDR  = '1;
  localparam logic [DW-1:0] KEY_BS     = 8'h08;
  localparam logic [DW-1:0] KEY_CR     = 8'h0D;
  localparam logic [DW-1:0] PRINT_LO   = 8'h20;
  localparam logic [DW-1:0] PRINT_HI   = 8'h7E;

`ifdef TEXT_BUFFER_SCROLL_EN
  localparam logic [AW-1:0] ROW_STRIDE = AW'(16);
  localparam logic [AW-1:0] SHIFT_LAST = AW'(47);
  localparam logic [AW-1:0] LAST_ROW   = AW'(48);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_CLEAR, S_SCROLL_RD, S_SCROLL_WR, S_SCROLL_CLR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_CLEAR
  } state_t;
`endif

  state_t          r_state;
  logic [AW-1:0]   r_cursor;
  logic [AW-1:0]   r_ram_addr;
  logic [DW-1:0]   r_ram_wdata;
  logic            r_ram_we;
  logic [DW-1:0]   r_key;

  logic            w_idle;
  logic            w_in_printable;
  logic            w_key_printable;
  logic            w_key_bs;
  logic            w_key_cr;
  logic [AW-1:0]   w_cursor_next;

  assign w_idle    = (r_state == S_IDLE);
  assign key_ready = w_idle & ~clear_req;
  assign busy      = ~w_idle;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_we    = r_ram_we;
  assign cursor    = r_cursor;

  assign w_in_printable  = (key_data >= PRINT_LO) && (key_data <= PRINT_HI);
  assign w_key_printable = (r_key >= PRINT_LO) && (r_key <= PRINT_HI);
  assign w_key_bs        = (r_key == KEY_BS);
  assign w_key_cr        = (r_key == KEY_CR);

  // Cursor after the latched key; row/column overflow wraps naturally in 6 bits.
  always_comb begin
    w_cursor_next = r_cursor;
    if (w_key_printable) begin
      w_cursor_next = r_cursor + AW'(1);
    end else if (w_key_bs) begin
      if (r_cursor != '0) w_cursor_next = r_cursor - AW'(1);
    end else if (w_key_cr) begin
      w_cursor_next = {2'(r_cursor[5:4] + 2'd1), 4'h0};
    end
  end

`ifdef TEXT_BUFFER_SCROLL_EN
  logic w_overflow;
  assign w_overflow = (w_key_printable && (r_cursor == LAST_ADDR)) ||
                      (w_key_cr && (r_cursor[5:4] == 2'd3));
`else
  logic [DW-1:0] w_unused_rdata;
  assign w_unused_rdata = ram_rdata;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cursor    <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_key       <= '0;
    end else begin
      case (r_state)
        // Clear beats a simultaneous key; the key stays offered until accepted.
        S_IDLE: begin
          r_ram_we <= 1'b0;
          if (clear_req) begin
            r_state     <= S_CLEAR;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= '0;
            r_ram_wdata <= FILL_CHAR;
          end else if (key_valid) begin
            r_state <= S_WRITE;
            r_key   <= key_data;
            if (w_in_printable) begin
              r_ram_we    <= 1'b1;
              r_ram_addr  <= r_cursor;
              r_ram_wdata <= key_data;
            end else if ((key_data == KEY_BS) && (r_cursor != '0)) begin
              r_ram_we    <= 1'b1;
              r_ram_addr  <= r_cursor - AW'(1);
              r_ram_wdata <= FILL_CHAR;
            end
          end
        end

        S_WRITE: begin
          r_ram_we <= 1'b0;
`ifdef TEXT_BUFFER_SCROLL_EN
          if (w_overflow) begin
            r_state    <= S_SCROLL_RD;
            r_ram_addr <= ROW_STRIDE;
          end else begin
            r_cursor <= w_cursor_next;
            r_state  <= S_IDLE;
          end
`else
          r_cursor <= w_cursor_next;
          r_state  <= S_IDLE;
`endif
        end

        // 64 fill writes, then one closing cycle that homes the cursor.
        S_CLEAR: begin
          if (r_ram_we) begin
            if (r_ram_addr == LAST_ADDR) r_ram_we <= 1'b0;
            else                         r_ram_addr <= r_ram_addr + AW'(1);
          end else begin
            r_cursor <= '0;
            r_state  <= S_IDLE;
          end
        end

`ifdef TEXT_BUFFER_SCROLL_EN
        // Read data for the source address is captured at the end of the read cycle.
        S_SCROLL_RD: begin
          r_state     <= S_SCROLL_WR;
          r_ram_wdata <= ram_rdata;
          r_ram_addr  <= r_ram_addr - ROW_STRIDE;
          r_ram_we    <= 1'b1;
        end

        S_SCROLL_WR: begin
          if (r_ram_addr == SHIFT_LAST) begin
            r_state     <= S_SCROLL_CLR;
            r_ram_addr  <= LAST_ROW;
            r_ram_wdata <= FILL_CHAR;
            r_ram_we    <= 1'b1;
          end else begin
            r_state    <= S_SCROLL_RD;
            r_ram_addr <= r_ram_addr + ROW_STRIDE + AW'(1);
            r_ram_we   <= 1'b0;
          end
        end

        S_SCROLL_CLR: begin
          if (r_ram_addr == LAST_ADDR) begin
            r_ram_we <= 1'b0;
            r_cursor <= LAST_ROW;
            r_state  <= S_IDLE;
          end else begin
            r_ram_addr <= r_ram_addr + AW'(1);
          end
        end
`endif

        default: begin
          r_state  <= S_IDLE;
          r_ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl with a small behavioural text RAM (asynchronous read, write on the rising edge).
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       clear_req;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic [5:0] cursor;
  logic       busy;

  logic [7:0] mem [64];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       obs_we;
  logic [5:0] obs_addr;
  logic [7:0] obs_wdata;
  int         obs_busy;

  always #5 clk = ~clk;

  text_buffer_ctrl #(.FILL_CHAR(8'h20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .clear_req (clear_req),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .cursor    (cursor),
    .busy      (busy)
  );

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one key at a negedge, record the first busy cycle, then wait for idle.
  task automatic press(input logic [7:0] k);
    int n;
    key_valid = 1'b1;
    key_data  = k;
    @(negedge clk);
    key_valid = 1'b0;
    obs_we    = ram_we;
    obs_addr  = ram_addr;
    obs_wdata = ram_wdata;
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    obs_busy = n;
    if (n >= 400) check("press_timeout", 32'(n), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int exp_a;
    int err;
    logic [7:0] exp_b;

    rst_n = 1'b0; key_valid = 1'b0; key_data = 8'h00; clear_req = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_we",     32'(ram_we),    32'd0);
    check("rst_addr",   32'(ram_addr),  32'd0);
    check("rst_wdata",  32'(ram_wdata), 32'd0);
    check("rst_cursor", 32'(cursor),    32'd0);
    check("rst_ready",  32'(key_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    press(8'h48);
    check("H_we",     32'(obs_we),    32'd1);
    check("H_addr",   32'(obs_addr),  32'd0);
    check("H_wdata",  32'(obs_wdata), 32'h48);
    check("H_busy",   32'(obs_busy),  32'd1);
    check("H_cursor", 32'(cursor),    32'd1);
    press(8'h69);
    check("i_we",     32'(obs_we),    32'd1);
    check("i_addr",   32'(obs_addr),  32'd1);
    check("i_wdata",  32'(obs_wdata), 32'h69);
    check("i_cursor", 32'(cursor),    32'd2);
    check("idle_we",  32'(ram_we),    32'd0);
    check("mem_1",    32'(mem[1]),    32'h69);

    pulse_reset();
    press(8'h08);
    check("bs0_we",     32'(obs_we),   32'd0);
    check("bs0_busy",   32'(obs_busy), 32'd1);
    check("bs0_cursor", 32'(cursor),   32'd0);
    repeat (5) press(8'h61);
    check("pre_bs_cursor", 32'(cursor), 32'd5);
    press(8'h08);
    check("bs5_we",     32'(obs_we),    32'd1);
    check("bs5_addr",   32'(obs_addr),  32'd4);
    check("bs5_wdata",  32'(obs_wdata), 32'h20);
    check("bs5_cursor", 32'(cursor),    32'd4);

    press(8'h01);
    check("ctl_we",     32'(obs_we),   32'd0);
    check("ctl_busy",   32'(obs_busy), 32'd1);
    check("ctl_cursor", 32'(cursor),   32'd4);
    press(8'h7F);
    check("del_we",     32'(obs_we),   32'd0);
    check("del_cursor", 32'(cursor),   32'd4);
    press(8'h1F);
    check("x1f_we",     32'(obs_we),   32'd0);
    press(8'h7E);
    check("x7e_we",     32'(obs_we),    32'd1);
    check("x7e_addr",   32'(obs_addr),  32'd4);
    check("x7e_wdata",  32'(obs_wdata), 32'h7E);
    check("x7e_cursor", 32'(cursor),    32'd5);

    // Clear with a simultaneous key; a repeated clear_req mid-clear must be ignored.
    clear_req = 1'b1; key_valid = 1'b1; key_data = 8'h51;
    #1;
    check("clr_key_ready", 32'(key_ready), 32'd0);
    @(negedge clk);
    clear_req = 1'b0;
    n = 0; exp_a = 0; err = 0;
    while (busy && n < 400) begin
      if (key_ready) err++;
      if (ram_we) begin
        if (ram_addr !== 6'(exp_a) || ram_wdata !== 8'h20) err++;
        exp_a++;
      end
      clear_req = (n == 20);
      n++;
      @(negedge clk);
    end
    clear_req = 1'b0;
    check("clr_busy",   32'(n),      32'd65);
    check("clr_writes", 32'(exp_a),  32'd64);
    check("clr_errs",   32'(err),    32'd0);
    check("clr_cursor", 32'(cursor), 32'd0);
    check("clr_ready",  32'(key_ready), 32'd1);
    check("clr_mem63",  32'(mem[63]), 32'h20);
    check("clr_mem1",   32'(mem[1]),  32'h20);
    @(negedge clk);
    key_valid = 1'b0;
    check("pend_we",    32'(ram_we),    32'd1);
    check("pend_addr",  32'(ram_addr),  32'd0);
    check("pend_wdata", 32'(ram_wdata), 32'h51);
    @(negedge clk);
    check("pend_cursor", 32'(cursor), 32'd1);

    press(8'h0D);
    check("cr_row1", 32'(cursor), 32'h10);
    check("cr_we",   32'(obs_we), 32'd0);
    repeat (7) press(8'h62);
    check("pre_cr17", 32'(cursor), 32'h17);
    press(8'h0D);
    check("cr17_cursor", 32'(cursor), 32'h20);
    check("cr17_we",     32'(obs_we), 32'd0);
    press(8'h0D);
    repeat (5) press(8'h63);
    check("pre_cr35", 32'(cursor), 32'h35);
    press(8'h0D);
`ifdef TEXT_BUFFER_SCROLL_EN
    check("cr35_cursor", 32'(cursor),   32'd48);
    check("cr35_busy",   32'(obs_busy), 32'd113);
`else
    check("cr35_cursor", 32'(cursor),   32'd0);
    check("cr35_busy",   32'(obs_busy), 32'd1);
`endif

    // Overflow with a printable at the last cell.
    pulse_reset();
    repeat (3) press(8'h0D);
    repeat (15) press(8'h44);
    check("pre_ovf_cursor", 32'(cursor), 32'd63);
    for (int i = 0; i < 48; i++) mem[i] = 8'h41 + 8'(i / 16);
    press(8'h5A);
    check("ovf_we",    32'(obs_we),    32'd1);
    check("ovf_addr",  32'(obs_addr),  32'd63);
    check("ovf_wdata", 32'(obs_wdata), 32'h5A);
`ifdef TEXT_BUFFER_SCROLL_EN
    check("scr_busy",   32'(obs_busy), 32'd113);
    check("scr_cursor", 32'(cursor),   32'd48);
    err = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < 32)       exp_b = 8'h42 + 8'(i / 16);
      else if (i < 47)  exp_b = 8'h44;
      else if (i == 47) exp_b = 8'h5A;
      else              exp_b = 8'h20;
      if (mem[i] !== exp_b) err++;
    end
    check("scr_mem_errs", 32'(err),     32'd0);
    check("scr_mem47",    32'(mem[47]), 32'h5A);
    check("scr_mem16",    32'(mem[16]), 32'h43);
`else
    check("wrap_busy",   32'(obs_busy), 32'd1);
    check("wrap_cursor", 32'(cursor),   32'd0);
    check("wrap_mem63",  32'(mem[63]),  32'h5A);
`endif

    // Reset in the middle of a clear.
    press(8'h78);
    press(8'h79);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (ram_addr != 6'd10 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mid_addr", 32'(ram_addr), 32'd10);
    check("mid_we",   32'(ram_we),   32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_we",     32'(ram_we), 32'd0);
    check("mid_rst_cursor", 32'(cursor), 32'd0);
    check("mid_rst_busy",   32'(busy),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_after_we", 32'(ram_we),  32'd0);
    check("mid_mem9",     32'(mem[9]),  32'h20);
`ifdef TEXT_BUFFER_SCROLL_EN
    check("mid_mem11",    32'(mem[11]), 32'h42);
`else
    check("mid_mem11",    32'(mem[11]), 32'h41);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 Parameter FILL_CHAR, default 8'h20, blank character used for clear, backspace and scroll fill.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 key_valid  in  1  ASCII code on key_data is offered this cycle.
REQ-005 key_data  in  8  ASCII code from keyboard decoder.
REQ-006 key_ready  out  1  controller accepts key this cycle; acceptance = key_valid & key_ready at a rising edge.
REQ-007 clear_req  in  1  single-cycle request to blank the whole 64-byte text buffer.
REQ-008 ram_addr  out  6  text RAM write/read address; row = addr[5:4], column = addr[3:0].
REQ-009 ram_wdata  out  8  text RAM write data.
REQ-010 ram_we  out  1  text RAM write enable, one byte per cycle.
REQ-011 ram_rdata  in  8  text RAM read data, valid one cycle after ram_addr is driven; used only with SCROLL_EN.
REQ-012 cursor  out  6  current write position.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_CLR; ram_addr, ram_wdata, ram_we, cursor are registered.
REQ-015 key_ready = (state==IDLE) & ~clear_req; clear_req in IDLE wins over a simultaneous key, which stays pending and is not accepted.
REQ-016 clear_req outside IDLE is ignored.
REQ-017 Key accepted at edge N -> WRITE; action visible during cycle N+1; cursor updated at edge N+1; return to IDLE unless scroll is entered.
REQ-018 Printable 0x20-0x7E: ram_we=1, ram_addr=cursor, ram_wdata=key; cursor+1.
REQ-019 Backspace 0x08: cursor>0 -> cursor-1, write FILL_CHAR at cursor-1; cursor==0 -> no write, cursor unchanged.
REQ-020 Enter 0x0D: cursor -> {cursor[5:4]+1, 4'h0}; no RAM write.
REQ-021 Any other code: consumed, no write, cursor unchanged, one WRITE cycle.
REQ-022 Overflow (printable at cursor 63, or Enter on row 3): without SCROLL_EN, cursor wraps to 0.
REQ-023 CLEAR: 64 consecutive cycles, ram_we=1, ram_addr 0..63 ascending, ram_wdata=FILL_CHAR; then cursor=0 and IDLE; clear completes in 65 cycles from acceptance.
REQ-024 ram_we=0 in IDLE; ram_addr holds its last value.

Reset
REQ-025 rst_n low at an edge: state=IDLE, cursor=0, ram_addr=0, ram_wdata=0, ram_we=0, busy=0.
REQ-026 Reset during CLEAR or scroll aborts immediately; RAM contents are left partially updated; RAM itself is not cleared by reset.

Configuration
REQ-027 Macro TEXT_BUFFER_SCROLL_EN compiled in: overflow per REQ-022 performs scroll instead of wrap.
REQ-028 Scroll, for i=0..47: SCROLL_RD drives ram_addr=i+16, ram_we=0; next cycle SCROLL_WR drives ram_addr=i, ram_we=1, ram_wdata=ram_rdata.
REQ-029 After i=47: SCROLL_CLR writes FILL_CHAR to 48..63, one per cycle; then cursor=48 and IDLE.
REQ-030 The overflowing printable is written at 63 first, in WRITE, then shifted with row 3; total busy = 1+96+16 cycles.
REQ-031 Macro absent: SCROLL_* states and ram_rdata use are removed; ram_rdata is left unconnected.

Verification
REQ-032 Reset, then keys 'H','i' -> writes 0x48@0, 0x69@1, cursor=2, each write one cycle after acceptance.
REQ-033 cursor=0, backspace -> no ram_we, cursor 0; cursor=5, backspace -> FILL_CHAR@4, cursor 4.
REQ-034 cursor=0x17, Enter -> cursor 0x20; cursor=0x35, Enter without macro -> cursor 0.
REQ-035 clear_req with key_valid in the same cycle -> key_ready=0, 64 writes of 0x20 to addresses 0..63, busy for 65 cycles, then the key is accepted.
REQ-036 With TEXT_BUFFER_SCROLL_EN: preload row r with byte 0x41+r, cursor=63, key 'Z' -> rows 0..2 hold old rows 1..3 (row 2 = 'D'x15+'Z'), row 3 = 0x20, cursor=48, busy 113 cycles.
REQ-037 rst_n low mid-CLEAR at address 10 -> ram_we=0 next cycle, cursor=0, state IDLE.
